// File: rtl/bus_pkg.sv
// Shared types and constants for the bus-share arbiter slice.
package bus_pkg;

  // Default width of each requester data bus and of the output bus.
  localparam int BUS_DATA_W = 4;

  // Mux select encoding.
  localparam logic SEL_P0 = 1'b0;
  localparam logic SEL_P1 = 1'b1;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } bus_state_e;

endpackage : bus_pkg

// File: rtl/bus_mux2.sv
// 2:1 DATA_W-wide bus multiplexer; the select line is owned by the arbiter.
module bus_mux2
  import bus_pkg::*;
#(
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic [DATA_W-1:0] y
);

  // Pure combinational select; no state in the data path.
  assign y = (sel == SEL_P1) ? d1 : d0;

endmodule : bus_mux2

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one 2:1 bus mux between two requesters.
// Grants and the mux select are registered; out_valid/out_data are
// combinational from the owner's request/data and the registered state.
// Optional burst limiting is compiled in with BUS_ARB_BURST_LIMIT_EN.
module bus_share_arbiter
  import bus_pkg::*;
#(
  parameter int DATA_W    = BUS_DATA_W,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // A burst limit below one transfer has no meaning.
  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("bus_share_arbiter: MAX_BURST must be at least 1");
  end

  bus_state_e        state;
  logic              last;         // requester served most recently
  logic [DATA_W-1:0] mux_data;
  logic              own_req;      // current owner still requesting
  logic              other_req;    // the non-owner is requesting
  logic              xfer;         // handshake completes this cycle
  logic              burst_done;   // owner has used up its burst allowance
  logic              release_grant;

  bus_mux2 #(.DATA_W(DATA_W)) u_mux (
    .sel (sel),
    .d0  (data0),
    .d1  (data1),
    .y   (mux_data)
  );

  assign own_req   = ((state == OWN0) && req0) || ((state == OWN1) && req1);
  assign other_req = ((state == OWN0) && req1) || ((state == OWN1) && req0);
  assign out_valid = own_req;
  assign out_data  = (state == IDLE) ? '0 : mux_data;
  assign xfer      = out_valid && out_ready;

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_cnt_next;

  // Transfers under the current grant including this cycle's, saturating.
  // NOTE: always_comb assigns a default first so no path leaves the value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    burst_cnt_next = burst_cnt;
    if (xfer && (burst_cnt != CNT_MAX)) begin
      burst_cnt_next = burst_cnt + 1'b1;
    end
  end

  // The transfer that reaches the limit is the last one of the burst.
  assign burst_done = (burst_cnt_next == CNT_MAX);

  // Burst counter: cleared whenever the grant changes or the bus is idle.
  always_ff @(posedge clk) begin
    if (!rst_n || (state == IDLE) || release_grant) begin
      burst_cnt <= '0;
    end else begin
      burst_cnt <= burst_cnt_next;
    end
  end
`else
  assign burst_done = 1'b0;
`endif

  // Owner gives the bus up when it drops its request, or when its burst
  // allowance is spent and the other side is waiting.
  assign release_grant = (state != IDLE) && (!own_req || (burst_done && other_req));

  // Ownership FSM with registered grants, select and priority pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= SEL_P0;
    end else begin
      unique case (state)
        IDLE: begin
          // Tie goes to the requester that was not served last.
          if (req0 && (!req1 || last)) begin
            state <= OWN0;
            gnt0  <= 1'b1;
            sel   <= SEL_P0;
          end else if (req1) begin
            state <= OWN1;
            gnt1  <= 1'b1;
            sel   <= SEL_P1;
          end
        end
        OWN0: begin
          if (release_grant) begin
            last <= 1'b0;
            gnt0 <= 1'b0;
            if (req1) begin
              state <= OWN1;
              gnt1  <= 1'b1;
              sel   <= SEL_P1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OWN1: begin
          if (release_grant) begin
            last <= 1'b1;
            gnt1 <= 1'b0;
            if (req0) begin
              state <= OWN0;
              gnt0  <= 1'b1;
              sel   <= SEL_P0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
      endcase
    end
  end

endmodule : bus_share_arbiter

// File: tb/tb_bus_share_arbiter.sv
// Self-checking bench for bus_share_arbiter: a per-cycle ownership model plus
// directed scenarios with hand-computed expectations.
module tb_bus_share_arbiter;

  localparam int DATA_W    = 4;
  localparam int MAX_BURST = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data0 = '0;
  logic [DATA_W-1:0] data1 = '0;
  logic              gnt0, gnt1, sel, out_valid;
  logic [DATA_W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_share_arbiter #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 = nobody, 0/1 = requester id; cnt = transfers under this grant.
  int m_owner = -1;
  int m_last  = 1;
  int m_sel   = 0;
  int m_cnt   = 0;
  bit model_on = 1'b0;

  always @(posedge clk) begin : model
    int  nxt;
    int  other;
    int  used;
    bit  own_rq, oth_rq, give_up;
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 1;
      m_sel   <= 0;
      m_cnt   <= 0;
    end else if (m_owner < 0) begin
      nxt = -1;
      if (req0 && req1) nxt = 1 - m_last;
      else if (req0)    nxt = 0;
      else if (req1)    nxt = 1;
      if (nxt >= 0) begin
        m_owner <= nxt;
        m_sel   <= nxt;
      end
      m_cnt <= 0;
    end else begin
      other   = 1 - m_owner;
      own_rq  = (m_owner == 0) ? req0 : req1;
      oth_rq  = (m_owner == 0) ? req1 : req0;
      used    = m_cnt + ((own_rq && out_ready) ? 1 : 0);
      give_up = !own_rq;
`ifdef BUS_ARB_BURST_LIMIT_EN
      if (used >= MAX_BURST && oth_rq) give_up = 1'b1;
      if (used > MAX_BURST) used = MAX_BURST;
`endif
      if (give_up) begin
        m_last <= m_owner;
        m_cnt  <= 0;
        if (oth_rq) begin
          m_owner <= other;
          m_sel   <= other;
        end else begin
          m_owner <= -1;
        end
      end else begin
        m_cnt <= used;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin : compare
    logic              e_valid;
    logic [DATA_W-1:0] e_data;
    if (model_on) begin
      e_valid = ((m_owner == 0) && req0) || ((m_owner == 1) && req1);
      e_data  = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : '0;
      check("model.gnt0", 32'(gnt0), 32'(m_owner == 0));
      check("model.gnt1", 32'(gnt1), 32'(m_owner == 1));
      check("model.sel", 32'(sel), 32'(m_sel));
      check("model.out_valid", 32'(out_valid), 32'(e_valid));
      check("model.out_data", 32'(out_data), 32'(e_data));
    end
  end

  // Transfers observed per port (a handshake completes at the coming edge).
  int xfer_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (gnt0) xfer_cnt[0]++;
      else if (gnt1) xfer_cnt[1]++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic g0, input logic g1, input logic s,
                     input logic v, input logic [DATA_W-1:0] d);
    #1;
    check({name, ".gnt0"}, 32'(gnt0), 32'(g0));
    check({name, ".gnt1"}, 32'(gnt1), 32'(g1));
    check({name, ".sel"}, 32'(sel), 32'(s));
    check({name, ".out_valid"}, 32'(out_valid), 32'(v));
    check({name, ".out_data"}, 32'(out_data), 32'(d));
  endtask

  initial begin : stim
    int base;

    // Reset held 3 cycles with both requests high.
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    data0 = 4'h3; data1 = 4'hA; out_ready = 1'b1;
    tick();
    model_on = 1'b1;
    tick();
    tick();
    lit("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1;

    // First tie after reset goes to port 0.
    base = xfer_cnt[0];
    tick();
    lit("first_grant", 1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
    tick();
    lit("tie_own0", 1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
    tick();
    req0 = 1'b0;
    lit("tie_drop0", 1'b1, 1'b0, 1'b0, 1'b0, 4'h3);
    check("tie_xfers0", 32'(xfer_cnt[0] - base), 32'd2);
    tick();
    lit("handoff_to1", 1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    req0 = 1'b1; req1 = 1'b0;
    lit("swap_reqs", 1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
    tick();
    lit("handoff_to0", 1'b1, 1'b0, 1'b0, 1'b1, 4'h3);
    req0 = 1'b0;
    tick();
    lit("idle_a", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Backpressure: data held, grant held, nothing transferred.
    data0 = 4'h5; out_ready = 1'b0; req0 = 1'b1;
    base = xfer_cnt[0];
    tick();
    lit("bp_grant", 1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
    for (int i = 0; i < 4; i++) begin
      tick();
      lit("bp_hold", 1'b1, 1'b0, 1'b0, 1'b1, 4'h5);
    end
    // Request falls in the same cycle ready rises: no transfer.
    out_ready = 1'b1; req0 = 1'b0;
    tick();
    check("bp_xfers0", 32'(xfer_cnt[0] - base), 32'd0);
    lit("idle_b", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Single requester on port 1; sel holds its value back in IDLE.
    req1 = 1'b1; data1 = 4'hA;
    tick();
    lit("single1", 1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
    req1 = 1'b0;
    tick();
    lit("single_idle", 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

    // Both held with port 1 served last: port 0 first, burst limit applies.
    data0 = 4'h6; data1 = 4'h9; req0 = 1'b1; req1 = 1'b1;
    base = xfer_cnt[0];
    tick();
    lit("burst_start", 1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
    tick();
    tick();
    tick();
    check("burst_xfers0", 32'(xfer_cnt[0] - base), 32'd3);
`ifdef BUS_ARB_BURST_LIMIT_EN
    lit("burst_handoff", 1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
`else
    lit("burst_nolimit", 1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
`endif
    req1 = 1'b0;
    tick();
    lit("solo0", 1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
    for (int i = 0; i < 10; i++) begin
      tick();
      lit("solo0_hold", 1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
    end
    req1 = 1'b1;
    tick();
`ifdef BUS_ARB_BURST_LIMIT_EN
    lit("saturated_handoff", 1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
`else
    lit("saturated_nolimit", 1'b1, 1'b0, 1'b0, 1'b1, 4'h6);
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("idle_c.gnt0", 32'(gnt0), 32'd0);
    check("idle_c.gnt1", 32'(gnt1), 32'd0);

    // Mid-burst reset while port 1 owns the bus.
    req1 = 1'b1; data1 = 4'hC;
    tick();
    lit("own1", 1'b0, 1'b1, 1'b1, 1'b1, 4'hC);
    rst_n = 1'b0;
    tick();
    lit("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    rst_n = 1'b1; req1 = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_share_arbiter
